// File: rtl/smpl_pkg.sv
// Shared types for the stereo sample history queue.
package smpl_pkg;

    localparam int unsigned DW = 24;

    typedef enum logic [1:0] {
        FILL,
        IDLE,
        READ
    } state_t;

    typedef struct packed {
        logic [DW-1:0] lft;
        logic [DW-1:0] rght;
    } pair_t;

endpackage

// File: rtl/smpl_queue_if.sv
// Sample-in / burst-out bundle between the I2S receiver, the queue and the FIR stage.
interface smpl_queue_if #(
    parameter int unsigned DW = smpl_pkg::DW
) ();

    logic          wrt_smpl;
    logic [DW-1:0] lft_smpl;
    logic [DW-1:0] rght_smpl;
    logic          sequencing;
    logic [DW-1:0] lft_out;
    logic [DW-1:0] rght_out;
    logic          frm_done;
    logic          overrun;

    modport master (
        output wrt_smpl, lft_smpl, rght_smpl,
        input  sequencing, lft_out, rght_out, frm_done, overrun
    );

    modport slave (
        input  wrt_smpl, lft_smpl, rght_smpl,
        output sequencing, lft_out, rght_out, frm_done, overrun
    );

endinterface

// File: rtl/dp_smpl_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, no reset.
module dp_smpl_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 48,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/smpl_queue.sv
// Stereo sample history buffer: primes with NUM_TAPS-1 pairs, then replays the
// latest NUM_TAPS pairs (oldest first) as one burst per newly accepted pair.
module smpl_queue
    import smpl_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned NUM_TAPS = 1021
) (
    input logic        clk,
    input logic        rst_n,
    smpl_queue_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(NUM_TAPS + 1);
    localparam logic [CW-1:0] LAST_RD   = CW'(NUM_TAPS - 1);
    localparam logic [CW-1:0] LAST_FILL = CW'(NUM_TAPS - 2);

    state_t        state;
    logic [AW-1:0] new_ptr;
    logic [AW-1:0] old_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fill_cnt;
    logic [CW-1:0] rd_cnt;
    logic          rd_vld;
    logic          rd_last;
    logic          ram_we;
    logic          ram_re;
    pair_t         wr_pair;
    pair_t         rd_pair;

    assign wr_pair = '{lft: bus.lft_smpl, rght: bus.rght_smpl};
    assign ram_re  = (state == READ);

    // A pair arriving while the last burst pair is still on the outputs is dropped.
    always_comb begin
        ram_we = 1'b0;
        unique case (state)
            FILL:    ram_we = bus.wrt_smpl;
            IDLE:    ram_we = bus.wrt_smpl && !bus.frm_done;
            default: ram_we = 1'b0;
        endcase
    end

    dp_smpl_ram #(
        .DEPTH(DEPTH),
        .WIDTH(2 * DW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(new_ptr),
        .wdata(wr_pair),
        .re   (ram_re),
        .raddr(rd_ptr),
        .rdata(rd_pair)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FILL;
            new_ptr        <= '0;
            old_ptr        <= '0;
            rd_ptr         <= '0;
            fill_cnt       <= '0;
            rd_cnt         <= '0;
            rd_vld         <= 1'b0;
            rd_last        <= 1'b0;
            bus.sequencing <= 1'b0;
            bus.frm_done   <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.lft_out    <= '0;
            bus.rght_out   <= '0;
        end else begin
            // RAM data lags the read address by one cycle; outputs add one more.
            rd_vld         <= ram_re;
            rd_last        <= ram_re && (rd_cnt == LAST_RD);
            bus.sequencing <= rd_vld;
            bus.frm_done   <= rd_last;
            if (rd_vld) begin
                bus.lft_out  <= rd_pair.lft;
                bus.rght_out <= rd_pair.rght;
            end

            if (bus.wrt_smpl && !ram_we) begin
                bus.overrun <= 1'b1;
            end
            if (ram_we) begin
                new_ptr <= new_ptr + AW'(1);
            end

            unique case (state)
                FILL: begin
                    if (bus.wrt_smpl) begin
                        if (fill_cnt != '1) begin
                            fill_cnt <= fill_cnt + CW'(1);
                        end
                        if (fill_cnt == LAST_FILL) begin
                            state <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (ram_we) begin
                        rd_ptr <= old_ptr;
                        rd_cnt <= '0;
                        state  <= READ;
                    end
                end
                READ: begin
                    rd_ptr <= rd_ptr + AW'(1);
                    rd_cnt <= rd_cnt + CW'(1);
                    if (rd_cnt == LAST_RD) begin
                        old_ptr <= old_ptr + AW'(1);
                        state   <= IDLE;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_smpl_queue.sv
// Bench for smpl_queue: directed prime/steady/wrap/overrun/reset scenarios and a
// random phase, all checked every cycle against a queue-based history model.
module tb_smpl_queue;
    import smpl_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int          T     = 8;

    logic clk;
    logic rst_n;

    smpl_queue_if #(.DW(DW)) bus ();

    smpl_queue #(
        .DEPTH   (DEPTH),
        .NUM_TAPS(T)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    // Model: accepted pairs since reset and the snapshot replayed by the current burst.
    pair_t         hist[$];
    pair_t         burst[$];
    bit            b_act;
    int            b_start;
    logic [DW-1:0] e_l, e_r;
    bit            e_seq, e_frm, e_ovr;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            if (err_cnt <= 50) $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        burst.delete();
        b_act = 1'b0;
        e_l   = '0;
        e_r   = '0;
        e_seq = 1'b0;
        e_frm = 1'b0;
        e_ovr = 1'b0;
    endtask

    task automatic model_edge(input bit wr, input logic [DW-1:0] l, input logic [DW-1:0] r);
        int    off;
        pair_t p;
        e_seq = 1'b0;
        e_frm = 1'b0;
        if (b_act) begin
            off = cyc - b_start - 2;
            if (off >= 0 && off < T) begin
                e_seq = 1'b1;
                e_l   = burst[off].lft;
                e_r   = burst[off].rght;
                e_frm = (off == T - 1);
            end
        end
        if (wr) begin
            p.lft  = l;
            p.rght = r;
            if (hist.size() < T - 1) begin
                hist.push_back(p);
            end else if (b_act && ((cyc >= b_start + 1 && cyc <= b_start + T) ||
                                   cyc == b_start + T + 2)) begin
                e_ovr = 1'b1;
            end else begin
                hist.push_back(p);
                burst   = hist;
                b_start = cyc;
                b_act   = 1'b1;
                void'(hist.pop_front());
            end
        end
    endtask

    task automatic compare();
        chk("sequencing", DW'(bus.sequencing), DW'(e_seq));
        chk("frm_done",   DW'(bus.frm_done),   DW'(e_frm));
        chk("overrun",    DW'(bus.overrun),    DW'(e_ovr));
        chk("lft_out",    bus.lft_out,         e_l);
        chk("rght_out",   bus.rght_out,        e_r);
    endtask

    task automatic step(input bit wr, input logic [DW-1:0] l, input logic [DW-1:0] r);
        bus.wrt_smpl  = wr;
        bus.lft_smpl  = l;
        bus.rght_smpl = r;
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge(wr, l, r);
        else model_reset();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), DW'($urandom));
    endtask

    task automatic wr(input int k);
        step(1'b1, DW'(k), DW'(100 + k));
    endtask

    // Runs the burst after an accepted write; optionally injects pair 99 at step ovr_at.
    task automatic burst_lits(input int first, input int ovr_at);
        for (int i = 0; i <= T; i++) begin
            if (i == ovr_at) step(1'b1, DW'(99), DW'(199));
            else step(1'b0, DW'(0), DW'(0));
            if (i >= 1) begin
                chk("lit_lft",  bus.lft_out,  DW'(first + i - 1));
                chk("lit_rght", bus.rght_out, DW'(100 + first + i - 1));
                chk("lit_seq",  DW'(bus.sequencing), DW'(1));
            end
            if (i == T) chk("lit_frm", DW'(bus.frm_done), DW'(1));
        end
    endtask

    task automatic areset();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        chk("arst_seq", DW'(bus.sequencing), DW'(0));
        step(1'b0, DW'(0), DW'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) step(1'($urandom), DW'($urandom), DW'($urandom));
        chk("rst_lft", bus.lft_out, DW'(0));
        chk("rst_ovr", DW'(bus.overrun), DW'(0));
        rst_n = 1'b1;
        idle(2);

        // Prime with 1..7: no output activity.
        for (int k = 1; k <= 7; k++) wr(k);
        idle(3);
        chk("prime_quiet", DW'(bus.sequencing), DW'(0));
        wr(8);
        burst_lits(1, -1);
        idle(2);

        wr(9);
        burst_lits(2, -1);
        idle(2);

        // Walk the pointers past the DEPTH wrap; overrun injected into the k=20 burst.
        for (int k = 10; k <= 19; k++) begin
            wr(k);
            idle(T + 3);
        end
        wr(20);
        burst_lits(13, 2);
        idle(2);
        chk("ovr_sticky", DW'(bus.overrun), DW'(1));
        wr(21);
        burst_lits(14, -1);
        idle(2);

        // Reset mid-burst, then re-prime.
        wr(22);
        idle(3);
        areset();
        for (int k = 31; k <= 37; k++) wr(k);
        idle(3);
        chk("reprime_quiet", DW'(bus.sequencing), DW'(0));
        wr(38);
        burst_lits(31, -1);
        idle(2);

        // Random traffic, including writes landing on burst boundaries.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) areset();
            else step($urandom_range(0, 3) == 0, DW'($urandom), DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/smpl_queue.md
Name: smpl_queue

Overview:
Stereo sample history buffer directly downstream of the I2S serial receiver. It captures each valid left/right sample pair into a circular buffer. Once primed, each new sample replays the most recent NUM_TAPS pairs, oldest first, as a contiguous burst. The burst feeds the downstream FIR/equalizer tap-multiply stage, which consumes one pair per clock while `sequencing` is high.

Parameters:
DW, 24, sample width per channel
DEPTH, 1024, buffer entries (power of 2, DEPTH >= NUM_TAPS)
NUM_TAPS, 1021, pairs replayed per new sample (>= 2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
wrt_smpl  in  1  one-cycle strobe, new pair valid (driven by receiver vld)
lft_smpl  in  DW  left sample in
rght_smpl  in  DW  right sample in
sequencing  out  1  high while lft_out/rght_out carry a valid replayed pair
lft_out  out  DW  replayed left sample
rght_out  out  DW  replayed right sample
frm_done  out  1  one-cycle pulse coincident with the last pair of a burst
overrun  out  1  sticky: a sample was dropped because it arrived mid-burst

Behaviour:
- Reset (async):
  - new_ptr=0, old_ptr=0, rd_ptr=0, fill_cnt=0, state=FILL.
  - sequencing=0, frm_done=0, overrun=0, lft_out=0, rght_out=0.
  - RAM contents are not reset.
- Storage:
  - One 2*DW-wide entry per pair, {lft,rght}.
  - Synchronous write; synchronous read with 1-cycle latency.
  - All pointers wrap modulo DEPTH with natural log2(DEPTH)-bit rollover.
- FILL state:
  - Each wrt_smpl writes at new_ptr, then new_ptr++ and fill_cnt++.
  - After NUM_TAPS-1 writes, go to IDLE. No output activity in FILL.
- IDLE state (buffer holds NUM_TAPS-1 pairs, old_ptr..new_ptr-1):
  - On wrt_smpl: write at new_ptr, new_ptr++, rd_ptr<=old_ptr, rd_cnt<=0, go to READ.
- READ state:
  - Issue one RAM read per cycle at rd_ptr; rd_ptr++ and rd_cnt++.
  - Leave READ after NUM_TAPS reads issued; at that point old_ptr++ and return to IDLE.
  - Outputs are registered from RAM data, one cycle behind the read address.
- Latency:
  - wrt_smpl sampled high at edge N.
  - sequencing is high for exactly NUM_TAPS consecutive cycles, edges N+2 through N+1+NUM_TAPS.
  - First pair out is the oldest stored pair; the last pair out is the just-written pair.
  - frm_done is high on the cycle of the last pair.
- Outputs when sequencing=0: lft_out/rght_out hold their last value; no consumer may use them.
- wrt_smpl during READ, or during the final trailing output cycle:
  - Pair is discarded; pointers are unaffected; overrun<=1.
  - overrun stays set until reset.
  - The burst in progress completes unchanged.
- wrt_smpl in the same cycle that IDLE is re-entered is accepted normally.
- fill_cnt saturates; it is unused after FILL.
- Reset mid-burst:
  - Burst aborts immediately; sequencing=0.
  - The queue re-enters FILL and must be re-primed with NUM_TAPS-1 writes.
- Steady state: the buffer never holds more than NUM_TAPS pairs, so no full/empty flags are exported.

Decomposition:
- Package smpl_pkg:
  - DW constant.
  - State enum typedef {FILL, IDLE, READ}.
  - Packed stereo pair typedef {lft,rght}.
- One sub-module: dp_smpl_ram.
  - Parameterised DEPTH x 2*DW.
  - One write port, one registered read port, no reset.
  - Coded for block-RAM inference.

Test Plan:
- Reset: with any inputs, hold rst_n=0 -> all outputs 0. Assert rst_n low asynchronously mid-clock -> outputs clear before the next edge.
- Prime (DEPTH=16, NUM_TAPS=8):
  - Write pairs lft=k, rght=100+k for k=1..7 -> sequencing never rises.
  - Write k=8 -> sequencing high 8 cycles starting 2 cycles later; lft_out 1..8, rght_out 101..108; frm_done with 8.
- Steady: write k=9 after the burst -> lft_out 2..9; old_ptr advanced by exactly 1.
- Wrap: continue to k=20 (pointers wrap at 16) -> burst after k=20 outputs lft 13..20 contiguously, no glitch at the wrap.
- Overrun: assert wrt_smpl with k=99 on cycle 3 of a burst -> burst unchanged, overrun=1. The next accepted write k=21 yields 14..21, and 99 never appears.
- Reset mid-burst: rst_n low during cycle 4 of a burst -> sequencing=0 immediately. After release, 7 writes produce no burst and the 8th write produces a burst of exactly those 8 values.
